square_channel: RTL and testbench
=================================

SQUARE_CHANNEL -- requirements
Module: square_channel

Interface
REQ-001 SHALL have parameter FREQ_W, default 11, width of frequency data, period timer and sweep shadow.
REQ-002 SHALL have parameter VOL_W, default 4, width of volume and level.
REQ-003 SHALL have parameter LEN_W, default 6, width of length data and length counter.
REQ-004 SHALL have port ac97_bitclk, in, 1; the only clock; all logic on rising edge.
REQ-005 SHALL have port reset_b, in, 1; asynchronous, active-low reset.
REQ-006 SHALL have ports freq_tick, len_tick, sweep_tick and env_tick, each in, 1; single-cycle enables at 131072/256/128/64 Hz.
REQ-007 SHALL have port trigger, in, 1; single-cycle note start.
REQ-008 SHALL have ports sweep_time (in, 3), sweep_decreasing (in, 1) and num_sweep_shifts (in, 3).
REQ-009 SHALL have ports wave_duty (in, 2), length_data (in, LEN_W) and dont_loop (in, 1).
REQ-010 SHALL have ports initial_volume (in, VOL_W), envelope_increasing (in, 1) and num_envelope_sweeps (in, 3).
REQ-011 SHALL have ports frequency_data (in, FREQ_W), level (out, VOL_W, registered sample), on_flag (out, 1, channel active) and freq_out (out, FREQ_W, current shadow frequency).

Function
REQ-012 On trigger: on_flag=1; length counter = 2^LEN_W - length_data; period timer = 2^FREQ_W - frequency_data; duty step = 0; volume = initial_volume; envelope counter = num_envelope_sweeps; shadow = frequency_data; sweep counter = sweep_time.
REQ-013 When trigger occurs with initial_volume==0 and envelope_increasing==0 (DAC off), on_flag SHALL be 0.
REQ-014 Trigger SHALL take priority over every tick arriving in the same cycle; those ticks are discarded.
REQ-015 On freq_tick the period timer increments; on wrap from all-ones it reloads with 2^FREQ_W - shadow and the duty step advances 0..7, wrapping to 0.
REQ-016 Duty patterns SHALL be: 00 high at step 7; 01 high at steps 0 and 7; 10 high at steps 0, 5, 6, 7; 11 high at steps 1-6.
REQ-017 level SHALL be volume when on_flag=1 and the duty bit is high, else 0; it SHALL be registered and valid one cycle after the causing event.
REQ-018 On len_tick with dont_loop=1 and length counter non-zero, the counter decrements; reaching 0 clears on_flag. With dont_loop=0 length SHALL be ignored and the counter held.
REQ-019 On env_tick with num_envelope_sweeps non-zero, the envelope counter decrements; at 0 it reloads and volume steps ±1, saturating at 0 and 2^VOL_W-1. With num_envelope_sweeps=0 the volume SHALL be frozen.
REQ-020 Several ticks in one cycle SHALL all be processed; any disable source clears on_flag.
REQ-021 Once on_flag=0, timers SHALL continue to run, but level SHALL stay 0 until the next trigger.

Reset
REQ-022 reset_b low SHALL asynchronously force level=0, on_flag=0, freq_out=0 and all counters, duty step and volume to 0.
REQ-023 Reset mid-note SHALL abandon the note; after release the channel stays silent until a trigger.

Configuration
REQ-024 With SQUARE_SWEEP_EN defined, sweep_tick with sweep_time non-zero decrements the sweep counter; at 0 it reloads and computes new = shadow ± (shadow >> num_sweep_shifts) in FREQ_W+1 bits.
REQ-025 With SQUARE_SWEEP_EN, an increasing result above 2^FREQ_W-1 SHALL clear on_flag; otherwise, if num_sweep_shifts is non-zero, shadow = new.
REQ-026 Without SQUARE_SWEEP_EN, the sweep inputs and sweep_tick SHALL be ignored, no sweep logic SHALL be built, and shadow SHALL track frequency_data every cycle.

Structure
REQ-027 Shared package sound_pkg SHALL hold the duty pattern table, the duty code constants and the default parameter values.
REQ-028 Envelope logic SHALL be a sub-module volume_envelope (parametrised by VOL_W), reusable by the noise channel.

Verification
REQ-029 Trigger with frequency_data=0x7FC, wave_duty=10, initial_volume=15 -> duty step advances every 4 freq_ticks; level=15 on steps 0, 5, 6, 7 and 0 on the other steps.
REQ-030 dont_loop=1, length_data=62, trigger -> on_flag=1 after the first len_tick; on_flag=0 and level=0 after the second.
REQ-031 initial_volume=4, decreasing, num_envelope_sweeps=1 -> volume 3, 2, 1, 0 on successive env_ticks, then holds 0 on the fifth.
REQ-032 SQUARE_SWEEP_EN, frequency_data=0x400, shifts=1, increasing, sweep_time=1 -> freq_out=0x600 after the first sweep_tick; on_flag=0 after the second (0x900 overflows).
REQ-033 Trigger and len_tick in the same cycle -> length counter = 2^LEN_W - length_data, no decrement; reset_b low mid-note -> level=0 and on_flag=0 immediately, without waiting for a clock edge.
REQ-034 Trigger with initial_volume=0, decreasing -> on_flag remains 0 and level=0 across all ticks.

Source files
------------

// File: rtl/sound_pkg.sv
// sound_pkg: constants shared by the sound channels: default widths, duty codes
// and the square-wave duty pattern table.
package sound_pkg;
    localparam int FREQ_W_DEF = 11;
    localparam int VOL_W_DEF  = 4;
    localparam int LEN_W_DEF  = 6;
    typedef enum logic [1:0] {
        DUTY_12 = 2'b00,
        DUTY_25 = 2'b01,
        DUTY_50 = 2'b10,
        DUTY_75 = 2'b11
    } duty_e;
    // Row index is the duty code, bit n of a row is the output at duty step n.
    localparam logic [3:0][7:0] DUTY_TABLE = {8'h7E, 8'hE1, 8'h81, 8'h80};
    function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] step);
        return DUTY_TABLE[duty][step];
    endfunction
endpackage

// File: rtl/volume_envelope.sv
// volume_envelope: per-channel volume with a periodic +/-1 envelope, saturating
// at 0 and full scale; shared by the square and noise channels.
module volume_envelope
    import sound_pkg::*;
#(
    parameter int VOL_W = VOL_W_DEF
) (
    input  logic             ac97_bitclk,
    input  logic             reset_b,
    input  logic             trigger,
    input  logic             env_tick,
    input  logic [VOL_W-1:0] initial_volume,
    input  logic             envelope_increasing,
    input  logic [2:0]       num_envelope_sweeps,
    output logic [VOL_W-1:0] volume
);
    logic [2:0] env_cnt;
    always_ff @(posedge ac97_bitclk or negedge reset_b) begin
        if (!reset_b) begin
            env_cnt <= '0;
            volume  <= '0;
        end else if (trigger) begin
            env_cnt <= num_envelope_sweeps;
            volume  <= initial_volume;
        end else if (env_tick && num_envelope_sweeps != 3'd0) begin
            if (env_cnt <= 3'd1) begin
                env_cnt <= num_envelope_sweeps;
                volume  <= envelope_increasing ? (&volume ? volume : volume + 1'b1)
                                               : (volume == '0 ? volume : volume - 1'b1);
            end else begin
                env_cnt <= env_cnt - 3'd1;
            end
        end
    end
endmodule

// File: rtl/square_channel.sv
// square_channel: square-wave sound channel with duty, length and envelope control.
// Define SQUARE_SWEEP_EN to build the frequency sweep unit.
module square_channel
    import sound_pkg::*;
#(
    parameter int FREQ_W = FREQ_W_DEF,
    parameter int VOL_W  = VOL_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              ac97_bitclk,
    input  logic              reset_b,
    input  logic              freq_tick,
    input  logic              len_tick,
    input  logic              sweep_tick,
    input  logic              env_tick,
    input  logic              trigger,
    input  logic [2:0]        sweep_time,
    input  logic              sweep_decreasing,
    input  logic [2:0]        num_sweep_shifts,
    input  logic [1:0]        wave_duty,
    input  logic [LEN_W-1:0]  length_data,
    input  logic              dont_loop,
    input  logic [VOL_W-1:0]  initial_volume,
    input  logic              envelope_increasing,
    input  logic [2:0]        num_envelope_sweeps,
    input  logic [FREQ_W-1:0] frequency_data,
    output logic [VOL_W-1:0]  level,
    output logic              on_flag,
    output logic [FREQ_W-1:0] freq_out
);
    logic [FREQ_W-1:0] timer, timer_next, shadow;
    logic [LEN_W-1:0]  len_cnt, len_next;
    logic [2:0]        step, step_next;
    logic [VOL_W-1:0]  volume;
    logic              on_next, sweep_kill;

    volume_envelope #(.VOL_W(VOL_W)) u_env (
        .ac97_bitclk         (ac97_bitclk),
        .reset_b             (reset_b),
        .trigger             (trigger),
        .env_tick            (env_tick),
        .initial_volume      (initial_volume),
        .envelope_increasing (envelope_increasing),
        .num_envelope_sweeps (num_envelope_sweeps),
        .volume              (volume)
    );

`ifdef SQUARE_SWEEP_EN
    logic [2:0]    sweep_cnt;
    logic [FREQ_W:0] sweep_sum;
    assign sweep_sum  = sweep_decreasing ? {1'b0, shadow} - {1'b0, shadow >> num_sweep_shifts}
                                         : {1'b0, shadow} + {1'b0, shadow >> num_sweep_shifts};
    assign sweep_kill = sweep_tick && sweep_time != 3'd0 && sweep_cnt <= 3'd1 && sweep_sum[FREQ_W];
    always_ff @(posedge ac97_bitclk or negedge reset_b) begin
        if (!reset_b) begin
            sweep_cnt <= '0;
            shadow    <= '0;
        end else if (trigger) begin
            sweep_cnt <= sweep_time;
            shadow    <= frequency_data;
        end else if (sweep_tick && sweep_time != 3'd0) begin
            if (sweep_cnt <= 3'd1) begin
                sweep_cnt <= sweep_time;
                if (!sweep_sum[FREQ_W] && num_sweep_shifts != 3'd0)
                    shadow <= sweep_sum[FREQ_W-1:0];
            end else begin
                sweep_cnt <= sweep_cnt - 3'd1;
            end
        end
    end
`else
    logic sweep_unused;
    assign sweep_unused = ^{sweep_tick, sweep_time, sweep_decreasing, num_sweep_shifts};
    assign sweep_kill   = 1'b0;
    always_ff @(posedge ac97_bitclk or negedge reset_b) begin
        if (!reset_b)
            shadow <= '0;
        else
            shadow <= frequency_data;
    end
`endif

    assign freq_out = shadow;

    // The timer counts up from the frequency value, so a full period is
    // 2^FREQ_W - frequency ticks before it wraps out of all-ones.
    always_comb begin
        timer_next = timer;
        step_next  = step;
        len_next   = len_cnt;
        on_next    = on_flag;
        if (trigger) begin
            timer_next = frequency_data;
            step_next  = 3'd0;
            len_next   = LEN_W'(0) - length_data;
            on_next    = initial_volume != '0 || envelope_increasing;
        end else begin
            if (freq_tick) begin
                timer_next = &timer ? shadow : timer + 1'b1;
                step_next  = &timer ? step + 3'd1 : step;
            end
            if (len_tick && dont_loop && len_cnt != '0) begin
                len_next = len_cnt - 1'b1;
                on_next  = len_cnt == LEN_W'(1) ? 1'b0 : on_next;
            end
            on_next = sweep_kill ? 1'b0 : on_next;
        end
    end

    always_ff @(posedge ac97_bitclk or negedge reset_b) begin
        if (!reset_b) begin
            timer   <= '0;
            step    <= '0;
            len_cnt <= '0;
            on_flag <= 1'b0;
            level   <= '0;
        end else begin
            timer   <= timer_next;
            step    <= step_next;
            len_cnt <= len_next;
            on_flag <= on_next;
            level   <= (on_flag && duty_bit(wave_duty, step)) ? volume : '0;
        end
    end
endmodule

// File: tb/tb_square_channel.sv
// tb_square_channel: randomized and directed checks of square_channel against a
// tick-counting behavioural model.
module tb_square_channel;
    localparam int FREQ_W = 11;
    localparam int VOL_W  = 4;
    localparam int LEN_W  = 6;

    logic clk = 1'b0, reset_b = 1'b0;
    logic freq_tick = 0, len_tick = 0, sweep_tick = 0, env_tick = 0, trigger = 0;
    logic [2:0] sweep_time = 0, num_sweep_shifts = 0, num_envelope_sweeps = 0;
    logic sweep_decreasing = 0, dont_loop = 0, envelope_increasing = 0;
    logic [1:0] wave_duty = 0;
    logic [LEN_W-1:0] length_data = 0;
    logic [VOL_W-1:0] initial_volume = 0;
    logic [FREQ_W-1:0] frequency_data = 0;
    logic [VOL_W-1:0] level;
    logic on_flag;
    logic [FREQ_W-1:0] freq_out;

    int errors = 0, checks = 0;
    bit m_on;
    int m_vol, m_step, m_rem, m_len, m_env, m_swp, m_shadow, m_level;

    always #5 clk = ~clk;

    square_channel #(.FREQ_W(FREQ_W), .VOL_W(VOL_W), .LEN_W(LEN_W)) dut (
        .ac97_bitclk(clk), .reset_b(reset_b), .freq_tick(freq_tick), .len_tick(len_tick),
        .sweep_tick(sweep_tick), .env_tick(env_tick), .trigger(trigger),
        .sweep_time(sweep_time), .sweep_decreasing(sweep_decreasing),
        .num_sweep_shifts(num_sweep_shifts), .wave_duty(wave_duty),
        .length_data(length_data), .dont_loop(dont_loop), .initial_volume(initial_volume),
        .envelope_increasing(envelope_increasing), .num_envelope_sweeps(num_envelope_sweeps),
        .frequency_data(frequency_data), .level(level), .on_flag(on_flag), .freq_out(freq_out)
    );

    function automatic bit duty_high(int d, int s);
        case (d)
            0: return s == 7;
            1: return s == 0 || s == 7;
            2: return s == 0 || s >= 5;
            default: return s >= 1 && s <= 6;
        endcase
    endfunction

    task automatic model_reset();
        m_on = 0; m_vol = 0; m_step = 0; m_rem = 1 << FREQ_W;
        m_len = 0; m_env = 0; m_swp = 0; m_shadow = 0; m_level = 0;
    endtask

    // One clock of the model; m_rem is the number of freq_ticks left in the current step.
    task automatic model_step();
        int d, n;
        m_level = (m_on && duty_high(wave_duty, m_step)) ? m_vol : 0;
        if (!reset_b) begin
            model_reset();
            return;
        end
        if (trigger) begin
            m_on = initial_volume != 0 || envelope_increasing;
            m_rem = (1 << FREQ_W) - frequency_data;
            m_step = 0;
            m_len = ((1 << LEN_W) - length_data) % (1 << LEN_W);
            m_vol = initial_volume;
            m_env = num_envelope_sweeps;
            m_swp = sweep_time;
            m_shadow = frequency_data;
            return;
        end
        if (freq_tick) begin
            m_rem--;
            if (m_rem == 0) begin
                m_rem = (1 << FREQ_W) - m_shadow;
                m_step = (m_step + 1) % 8;
            end
        end
        if (len_tick && dont_loop && m_len > 0) begin
            m_len--;
            if (m_len == 0) m_on = 0;
        end
        if (env_tick && num_envelope_sweeps != 0) begin
            m_env--;
            if (m_env <= 0) begin
                m_env = num_envelope_sweeps;
                if (envelope_increasing) m_vol = m_vol < (1 << VOL_W) - 1 ? m_vol + 1 : m_vol;
                else m_vol = m_vol > 0 ? m_vol - 1 : 0;
            end
        end
`ifdef SQUARE_SWEEP_EN
        if (sweep_tick && sweep_time != 0) begin
            m_swp--;
            if (m_swp <= 0) begin
                m_swp = sweep_time;
                d = m_shadow >> num_sweep_shifts;
                n = sweep_decreasing ? m_shadow - d : m_shadow + d;
                if (n > (1 << FREQ_W) - 1) m_on = 0;
                else if (num_sweep_shifts != 0) m_shadow = n;
            end
        end
`else
        m_shadow = frequency_data;
`endif
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        {trigger, freq_tick, len_tick, sweep_tick, env_tick} = '0;
    endtask

    task automatic set_note(int fd, int duty, int iv, bit inc, int nes, int ld, bit dl);
        frequency_data = FREQ_W'(fd); wave_duty = 2'(duty); initial_volume = VOL_W'(iv);
        envelope_increasing = inc; num_envelope_sweeps = 3'(nes);
        length_data = LEN_W'(ld); dont_loop = dl;
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        checks += 3;
        if (level !== '0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        if (on_flag !== 1'b0) begin errors++; $display("FAIL reset_on got=%0b exp=0", on_flag); end
        if (freq_out !== '0) begin errors++; $display("FAIL reset_freq got=%0h exp=0", freq_out); end
        @(posedge clk); #1;
        cycle();
        reset_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            {freq_tick, len_tick, env_tick} = 3'($urandom);
            cycle();
            checks++;
            if (level !== '0 || on_flag !== 1'b0) begin
                errors++; $display("FAIL idle_silent level=%0d on=%0b exp 0/0", level, on_flag);
            end
        end
    endtask

    task automatic test_duty();
        int exp;
        set_note('h7FC, 2, 15, 0, 0, 0, 0);
        trigger = 1; cycle(); cycle();
        for (int k = 1; k <= 32; k++) begin
            freq_tick = 1; cycle(); cycle();
            exp = duty_high(2, (k / 4) % 8) ? 15 : 0;
            checks += 2;
            if (level !== VOL_W'(exp)) begin errors++; $display("FAIL duty50 tick=%0d got=%0d exp=%0d", k, level, exp); end
            if (level !== VOL_W'(m_level)) begin errors++; $display("FAIL duty50_model tick=%0d got=%0d exp=%0d", k, level, m_level); end
        end
        for (int d = 0; d < 4; d++) begin
            set_note($urandom_range('h7F0, 'h7FE), d, $urandom_range(1, 15), 0, 0, 0, 0);
            trigger = 1; cycle();
            for (int i = 0; i < 60; i++) begin
                freq_tick = $urandom_range(0, 1) == 1;
                cycle();
                checks++;
                if (level !== VOL_W'(m_level)) begin errors++; $display("FAIL duty%0d cyc=%0d got=%0d exp=%0d", d, i, level, m_level); end
            end
        end
    endtask

    task automatic test_length();
        set_note('h700, 2, 9, 0, 0, 62, 1);
        trigger = 1; cycle();
        len_tick = 1; cycle(); cycle();
        checks += 2;
        if (on_flag !== 1'b1) begin errors++; $display("FAIL len_first on got=%0b exp=1", on_flag); end
        if (level !== 4'd9) begin errors++; $display("FAIL len_first level got=%0d exp=9", level); end
        len_tick = 1; cycle(); cycle();
        checks += 2;
        if (on_flag !== 1'b0) begin errors++; $display("FAIL len_second on got=%0b exp=0", on_flag); end
        if (level !== '0) begin errors++; $display("FAIL len_second level got=%0d exp=0", level); end
        set_note('h700, 2, 9, 0, 0, 63, 0);
        trigger = 1; cycle();
        repeat (5) begin len_tick = 1; cycle(); end
        checks++;
        if (on_flag !== 1'b1) begin errors++; $display("FAIL len_loop on got=%0b exp=1", on_flag); end
    endtask

    task automatic test_envelope();
        int exp_v[5] = '{3, 2, 1, 0, 0};
        set_note('h700, 2, 4, 0, 1, 0, 0);
        trigger = 1; cycle();
        for (int i = 0; i < 5; i++) begin
            env_tick = 1; cycle(); cycle();
            checks++;
            if (level !== VOL_W'(exp_v[i])) begin errors++; $display("FAIL env_dec tick=%0d got=%0d exp=%0d", i + 1, level, exp_v[i]); end
        end
        set_note('h700, 2, 13, 1, 2, 0, 0);
        trigger = 1; cycle();
        for (int i = 0; i < 8; i++) begin
            env_tick = 1; cycle(); cycle();
            checks++;
            if (level !== VOL_W'(m_level)) begin errors++; $display("FAIL env_inc tick=%0d got=%0d exp=%0d", i + 1, level, m_level); end
        end
        checks++;
        if (level !== 4'd15) begin errors++; $display("FAIL env_sat got=%0d exp=15", level); end
        set_note('h700, 2, 6, 0, 0, 0, 0);
        trigger = 1; cycle();
        repeat (4) begin env_tick = 1; cycle(); end
        cycle();
        checks++;
        if (level !== 4'd6) begin errors++; $display("FAIL env_frozen got=%0d exp=6", level); end
    endtask

    task automatic test_priority();
        set_note('h7F8, 2, 7, 0, 1, 62, 1);
        trigger = 1; cycle();
        len_tick = 1; cycle();
        trigger = 1; len_tick = 1; env_tick = 1; freq_tick = 1; cycle(); cycle();
        checks += 2;
        if (on_flag !== 1'b1) begin errors++; $display("FAIL prio_on got=%0b exp=1", on_flag); end
        if (level !== 4'd7) begin errors++; $display("FAIL prio_level got=%0d exp=7", level); end
        len_tick = 1; cycle();
        checks++;
        if (on_flag !== 1'b1) begin errors++; $display("FAIL prio_len1 got=%0b exp=1", on_flag); end
        len_tick = 1; cycle();
        checks++;
        if (on_flag !== 1'b0) begin errors++; $display("FAIL prio_len2 got=%0b exp=0", on_flag); end
    endtask

    task automatic test_dac_off();
        set_note('h7F0, 3, 0, 0, 1, 40, 1);
        trigger = 1; cycle();
        for (int i = 0; i < 40; i++) begin
            {freq_tick, len_tick, env_tick, sweep_tick} = 4'($urandom);
            cycle();
            checks++;
            if (on_flag !== 1'b0 || level !== '0) begin
                errors++; $display("FAIL dac_off cyc=%0d on=%0b level=%0d exp 0/0", i, on_flag, level);
            end
        end
    endtask

    task automatic test_async_reset();
        set_note('h600, 2, 12, 0, 0, 0, 0);
        trigger = 1; cycle(); cycle();
        checks++;
        if (level !== 4'd12) begin errors++; $display("FAIL prereset_level got=%0d exp=12", level); end
        #2 reset_b = 1'b0;
        #1;
        checks += 2;
        if (level !== '0) begin errors++; $display("FAIL async_level got=%0d exp=0", level); end
        if (on_flag !== 1'b0) begin errors++; $display("FAIL async_on got=%0b exp=0", on_flag); end
        @(posedge clk); #1;
        model_reset();
        reset_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            {freq_tick, len_tick, env_tick} = 3'($urandom);
            cycle();
            checks++;
            if (on_flag !== 1'b0 || level !== '0) begin
                errors++; $display("FAIL post_reset cyc=%0d on=%0b level=%0d exp 0/0", i, on_flag, level);
            end
        end
    endtask

`ifdef SQUARE_SWEEP_EN
    task automatic test_sweep();
        set_note('h400, 2, 8, 0, 0, 0, 0);
        sweep_time = 1; num_sweep_shifts = 1; sweep_decreasing = 0;
        trigger = 1; cycle();
        sweep_tick = 1; cycle();
        checks += 2;
        if (freq_out !== 11'h600) begin errors++; $display("FAIL sweep1 freq got=%0h exp=600", freq_out); end
        if (on_flag !== 1'b1) begin errors++; $display("FAIL sweep1 on got=%0b exp=1", on_flag); end
        sweep_tick = 1; cycle();
        checks += 2;
        if (on_flag !== 1'b0) begin errors++; $display("FAIL sweep2 on got=%0b exp=0", on_flag); end
        if (freq_out !== 11'h600) begin errors++; $display("FAIL sweep2 freq got=%0h exp=600", freq_out); end
    endtask
`else
    task automatic test_sweep();
        set_note('h400, 2, 8, 0, 0, 0, 0);
        sweep_time = 1; num_sweep_shifts = 1; sweep_decreasing = 0;
        trigger = 1; cycle();
        for (int i = 0; i < 6; i++) begin
            frequency_data = FREQ_W'($urandom_range('h400, 'h7FF));
            sweep_tick = 1; cycle();
            checks += 2;
            if (freq_out !== frequency_data) begin errors++; $display("FAIL track freq got=%0h exp=%0h", freq_out, frequency_data); end
            if (on_flag !== 1'b1) begin errors++; $display("FAIL nosweep on got=%0b exp=1", on_flag); end
        end
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            set_note($urandom_range('h7C0, 'h7FF), $urandom_range(0, 3), $urandom_range(0, 15),
                     $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 63), $urandom_range(0, 1));
            sweep_time = 3'($urandom); num_sweep_shifts = 3'($urandom); sweep_decreasing = 1'($urandom);
            trigger = 1; cycle();
            for (int i = 0; i < 200; i++) begin
                freq_tick = $urandom_range(0, 1) == 1;
                len_tick = $urandom_range(0, 19) == 0;
                env_tick = $urandom_range(0, 9) == 0;
                sweep_tick = $urandom_range(0, 14) == 0;
                trigger = $urandom_range(0, 99) == 0;
                cycle();
                checks += 3;
                if (level !== VOL_W'(m_level)) begin errors++; $display("FAIL rnd_level n=%0d cyc=%0d got=%0d exp=%0d", n, i, level, m_level); end
                if (on_flag !== m_on) begin errors++; $display("FAIL rnd_on n=%0d cyc=%0d got=%0b exp=%0b", n, i, on_flag, m_on); end
                if (freq_out !== FREQ_W'(m_shadow)) begin errors++; $display("FAIL rnd_freq n=%0d cyc=%0d got=%0h exp=%0h", n, i, freq_out, m_shadow); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_duty();
        test_length();
        test_envelope();
        test_priority();
        test_dac_off();
        test_async_reset();
        test_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
